// File: rtl/posit_pkg.sv
// Shared types and helpers for the posit dot-product datapath.
// mant_accum uses the accumulator FSM state type defined here.
package posit_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/mant_accum.sv
// Group accumulator for aligned two's-complement mantissas; emits a sign-magnitude sum per group.
// Optional macro PDPU_ACC_SAT_EN clamps the accumulator on signed overflow instead of wrapping.
//
// state | meaning
// ACCUM | accepting beats, summing into acc_q
// HOLD  | group result presented, waiting for out_ready_i
module mant_accum
    import posit_pkg::*;
#(
    parameter int WIDTH     = 14,
    parameter int ACC_WIDTH = 20,
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_mant_i,
    input  logic                 in_last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_sign_o,
    output logic [ACC_WIDTH-1:0] out_mant_o,
    output logic                 out_ovf_o,
    output logic [CNT_WIDTH-1:0] out_cnt_o
);

    localparam int MSB = ACC_WIDTH - 1;
`ifdef PDPU_ACC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

    acc_state_e           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 out_sign_q, out_sign_d;
    logic [ACC_WIDTH-1:0] out_mant_q, out_mant_d;
    logic                 out_ovf_q, out_ovf_d;
    logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;

    logic [ACC_WIDTH-1:0] mant_ext;
    logic [ACC_WIDTH-1:0] sum_raw;
    logic [ACC_WIDTH-1:0] sum_eff;
    logic [ACC_WIDTH-1:0] sum_mag;
    logic                 beat_ovf;
    logic                 beat_acc;

    assign mant_ext = {{(ACC_WIDTH-WIDTH){in_mant_i[WIDTH-1]}}, in_mant_i};
    assign sum_raw  = acc_q + mant_ext;
    assign beat_ovf = (acc_q[MSB] == mant_ext[MSB]) && (sum_raw[MSB] != acc_q[MSB]);

    // On overflow the true sum has the sign of the (shared) operand sign.
`ifdef PDPU_ACC_SAT_EN
    assign sum_eff = beat_ovf ? (acc_q[MSB] ? SAT_MIN : SAT_MAX) : sum_raw;
`else
    assign sum_eff = sum_raw;
`endif

    // Negating the most negative value leaves 1 followed by zeros, which reads correctly unsigned.
    assign sum_mag  = sum_eff[MSB] ? ((~sum_eff) + ACC_WIDTH'(1)) : sum_eff;
    assign beat_acc = in_valid_i && (state_q == ACCUM);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        out_sign_d = out_sign_q;
        out_mant_d = out_mant_q;
        out_ovf_d  = out_ovf_q;
        out_cnt_d  = out_cnt_q;

        case (state_q)
            ACCUM: begin
                if (beat_acc) begin
                    if (in_last_i) begin
                        out_sign_d = sum_eff[MSB];
                        out_mant_d = sum_mag;
                        out_ovf_d  = ovf_q | beat_ovf;
                        out_cnt_d  = cnt_q + CNT_WIDTH'(1);
                        acc_d      = '0;
                        cnt_d      = '0;
                        ovf_d      = 1'b0;
                        state_d    = HOLD;
                    end else begin
                        acc_d = sum_eff;
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                        ovf_d = ovf_q | beat_ovf;
                    end
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_sign_q <= 1'b0;
            out_mant_q <= '0;
            out_ovf_q  <= 1'b0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_sign_q <= out_sign_d;
            out_mant_q <= out_mant_d;
            out_ovf_q  <= out_ovf_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    assign in_ready_o  = (state_q == ACCUM);
    assign out_valid_o = (state_q == HOLD);
    assign out_sign_o  = out_sign_q;
    assign out_mant_o  = out_mant_q;
    assign out_ovf_o   = out_ovf_q;
    assign out_cnt_o   = out_cnt_q;

endmodule

// File: tb/tb_mant_accum.sv
// Scoreboard bench for mant_accum at WIDTH=8, ACC_WIDTH=12, CNT_WIDTH=4.
// Expectations switch with PDPU_ACC_SAT_EN for the overflow groups.
module tb_mant_accum;

    localparam int W  = 8;
    localparam int AW = 12;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_mant;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [AW-1:0] out_mant;
    logic          out_ovf;
    logic [CW-1:0] out_cnt;

    typedef struct packed {
        logic          sign;
        logic [AW-1:0] mant;
        logic          ovf;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_pushed  = 0;
    int   n_results = 0;

    mant_accum #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_mant_i   (in_mant),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sign_o  (out_sign),
        .out_mant_o  (out_mant),
        .out_ovf_o   (out_ovf),
        .out_cnt_o   (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit s, input int m, input bit o, input int c);
        exp_t e;
        e.sign = s;
        e.mant = AW'(m);
        e.ovf  = o;
        e.cnt  = CW'(c);
        exp_q.push_back(e);
        n_pushed++;
    endtask

    // Presents one beat from a negedge; returns 1 time unit after the accepting posedge.
    task automatic send(input int m, input bit last);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_wait: in_ready stuck at 0, expected 1");
        end
        in_valid = 1'b1;
        in_mant  = m[W-1:0];
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            n_results++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_unexpected: result with mant %0d, expected none", out_mant);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_sign", int'(out_sign), int'(e.sign));
                check("mon_mant", int'(out_mant), int'(e.mant));
                check("mon_ovf",  int'(out_ovf),  int'(e.ovf));
                check("mon_cnt",  int'(out_cnt),  int'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mant   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_mant",  int'(out_mant),  0);
        check("rst_out_cnt",   int'(out_cnt),   0);
        check("rst_out_sign",  int'(out_sign),  0);
        check("rst_out_ovf",   int'(out_ovf),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic group with latency and one-cycle in_ready drop.
        push_exp(0, 6, 0, 3);
        send(5, 0);
        send(3, 0);
        send(-2, 1);
        check("lat_out_valid_hi", int'(out_valid), 1);
        check("lat_in_ready_lo",  int'(in_ready),  0);
        @(posedge clk);
        #1;
        check("lat_out_valid_lo", int'(out_valid), 0);
        check("lat_in_ready_hi",  int'(in_ready),  1);

        // Negative sum, with idle cycles mid-group.
        push_exp(1, 128, 0, 2);
        send(-100, 0);
        repeat (3) @(posedge clk);
        send(-28, 1);

        // Zero sum must not produce negative zero.
        push_exp(0, 0, 0, 2);
        send(7, 0);
        send(-7, 1);

        // Exactly most-negative sum, 16 beats wraps the counter to 0.
        push_exp(1, 2048, 0, 0);
        for (int i = 0; i < 16; i++) send(-128, i == 15);

        // 17 x 127 = 2159 exceeds +2047.
`ifdef PDPU_ACC_SAT_EN
        push_exp(0, 2047, 1, 1);
`else
        push_exp(1, 1937, 1, 1);
`endif
        for (int i = 0; i < 17; i++) send(127, i == 16);

        // 17 x -128 overflows negative, then +127.
`ifdef PDPU_ACC_SAT_EN
        push_exp(1, 1921, 1, 2);
`else
        push_exp(0, 2047, 1, 2);
`endif
        for (int i = 0; i < 17; i++) send(-128, 0);
        send(127, 1);

        // Downstream stall with in_valid held high in HOLD.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push_exp(0, 3, 0, 2);
        send(1, 0);
        send(2, 1);
        in_valid = 1'b1;
        in_mant  = 8'd50;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_in_ready",  int'(in_ready),  0);
            check("stall_out_mant",  int'(out_mant),  3);
            check("stall_out_cnt",   int'(out_cnt),   2);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        push_exp(0, 4, 0, 1);
        send(4, 1);

        // Reset mid-group discards partial sum.
        send(10, 0);
        send(20, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  int'(in_ready),  1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_mant",  int'(out_mant),  0);
        check("mid_rst_out_cnt",   int'(out_cnt),   0);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(0, 9, 0, 1);
        send(9, 1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        repeat (2) @(posedge clk);
        check("drain_queue_empty", exp_q.size(), 0);
        check("result_count",      n_results,    n_pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
